// File: rtl/mux8_select_serializer.sv
// mux8_select_serializer
//   Accepts 8-bit words over a valid/ready handshake and buffers one more word
//   in a single skid slot. For each word it steps the 3-bit select of the
//   downstream 8:1 mux through all eight positions, one position per
//   downstream handshake, and also drives the selected bit. This lets the same
//   stage work on its own as a parallel-to-serial converter.
//
// Parameters
//   MSB_FIRST : 0 emits a[0]..a[7], 1 emits a[7]..a[0]
//   IDLE_BIT  : value driven on m_bit while m_valid=0
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   s_data, s_valid, s_ready upstream word handshake
//   m_ready, m_valid         downstream beat handshake
//   m_bit                    word[{sel_en0,sel_en1,sel_en2}]
//   m_last                   high on the 8th beat of a word
//   sel_en0/1/2              mux select, en0 is the MSB
//   busy                     shifting a word or pending slot occupied
module mux8_select_serializer #(
    parameter bit MSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       m_ready,
    output logic       m_valid,
    output logic       m_bit,
    output logic       m_last,
    output logic       sel_en0,
    output logic       sel_en1,
    output logic       sel_en2,
    output logic       busy
);

    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] START_IDX = MSB_FIRST ? IDX_W'(7) : IDX_W'(0);
    localparam logic [IDX_W-1:0] END_IDX   = MSB_FIRST ? IDX_W'(0) : IDX_W'(7);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       word_q;
    logic [7:0]       pend_q;
    logic             pend_vld;

    logic             accept;
    logic             beat;
    logic             last_beat;
    logic [IDX_W-1:0] idx_step;

    // Handshake decodes; s_ready comes from registers only.
    assign s_ready   = ~pend_vld;
    assign accept    = s_valid & s_ready;
    assign beat      = m_valid & m_ready;
    assign last_beat = beat & (idx == END_IDX);
    assign idx_step  = MSB_FIRST ? idx - IDX_W'(1) : idx + IDX_W'(1);

    // Output decodes of the state registers; select lines and bit are parked while idle.
    assign m_valid = (state == SHIFT);
    assign m_last  = m_valid & (idx == END_IDX);
    assign m_bit   = m_valid ? word_q[idx] : IDLE_BIT;
    assign {sel_en0, sel_en1, sel_en2} = m_valid ? idx : IDX_W'(0);
    assign busy    = m_valid | pend_vld;

    // Serializer FSM with active word and one-deep skid slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= IDX_W'(0);
            pend_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= s_data;
                        idx    <= START_IDX;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_beat) begin
                        idx <= START_IDX;
                        if (pend_vld) begin
                            // Reload from the skid slot: no bubble between words.
                            word_q   <= pend_q;
                            pend_vld <= 1'b0;
                        end else if (accept) begin
                            // Empty slot and a word arriving now: bypass straight in.
                            word_q <= s_data;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (beat) begin
                            idx <= idx_step;
                        end
                        if (accept) begin
                            pend_q   <= s_data;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_select_serializer.sv
module tb_mux8_select_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       m_ready;

    logic s_ready_l, m_valid_l, m_bit_l, m_last_l, sel0_l, sel1_l, sel2_l, busy_l;
    logic s_ready_m, m_valid_m, m_bit_m, m_last_m, sel0_m, sel1_m, sel2_m, busy_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux8_select_serializer #(.MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l),
        .m_ready(m_ready), .m_valid(m_valid_l), .m_bit(m_bit_l), .m_last(m_last_l),
        .sel_en0(sel0_l), .sel_en1(sel1_l), .sel_en2(sel2_l), .busy(busy_l)
    );

    mux8_select_serializer #(.MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_m),
        .m_ready(m_ready), .m_valid(m_valid_m), .m_bit(m_bit_m), .m_last(m_last_m),
        .sel_en0(sel0_m), .sel_en1(sel1_m), .sel_en2(sel2_m), .busy(busy_m)
    );

    // Packed observation: {m_valid, m_last, m_bit, sel[2:0], busy, s_ready}
    logic [7:0] obs_l, obs_m;
    assign obs_l = {m_valid_l, m_last_l, m_bit_l, sel0_l, sel1_l, sel2_l, busy_l, s_ready_l};
    assign obs_m = {m_valid_m, m_last_m, m_bit_m, sel0_m, sel1_m, sel2_m, busy_m, s_ready_m};

    function automatic logic [7:0] ev(input logic v, input logic last, input logic b,
                                      input logic [2:0] s, input logic bz, input logic rdy);
        return {v, last, b, s, bz, rdy};
    endfunction

    task automatic check(input string tag, input int step, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed %b expected %b", tag, step, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] w;
    logic [7:0] w3 [3];
    int         fi;
    int         beats;
    int         cyc;
    logic       acc;
    logic       pat [8];

    initial begin
        w3  = '{8'h0F, 8'hF0, 8'h3C};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_lsb", 0, obs_l, ev(0, 0, 0, 3'd0, 0, 1));
        check("reset_msb", 0, obs_m, ev(0, 0, 0, 3'd0, 0, 1));

        // Single word, both orders.
        w = 8'hB4; s_data = w; s_valid = 1'b1; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("single_lsb", k, obs_l, ev(1, k == 7, w[k], 3'(k), 1, 1));
            check("single_msb", k, obs_m, ev(1, k == 7, w[7-k], 3'(7-k), 1, 1));
            tick();
        end
        check("single_idle_lsb", 0, obs_l, ev(0, 0, 0, 3'd0, 0, 1));
        check("single_idle_msb", 0, obs_m, ev(0, 0, 0, 3'd0, 0, 1));

        // Back-to-back words with s_valid held high.
        s_data = w3[0]; s_valid = 1'b1; m_ready = 1'b1;
        tick();
        fi = 1; s_data = w3[1];
        for (int c = 0; c < 24; c++) begin
            check("b2b_lsb", c, obs_l,
                  ev(1, (c % 8) == 7, w3[c/8][c%8], 3'(c % 8), 1, (c == 0 || c == 8 || c >= 16)));
            acc = s_valid & s_ready_l;
            tick();
            if (acc) fi++;
            s_valid = (fi < 3);
            if (fi < 3) s_data = w3[fi];
        end
        check("b2b_accepted", 0, 8'(fi), 8'd3);
        check("b2b_idle_lsb", 0, obs_l, ev(0, 0, 0, 3'd0, 0, 1));

        // Backpressure: outputs hold while m_ready=0.
        w = 8'h5A; s_data = w; s_valid = 1'b1; m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 8 && cyc < 40) begin
            m_ready = pat[cyc % 8];
            check("bp_lsb", cyc, obs_l, ev(1, beats == 7, w[beats], 3'(beats), 1, 1));
            tick();
            if (m_ready) beats++;
            cyc++;
        end
        m_ready = 1'b1;
        check("bp_beats", cyc, 8'(beats), 8'd8);
        check("bp_idle_lsb", 0, obs_l, ev(0, 0, 0, 3'd0, 0, 1));

        // Bypass on the last beat with the skid slot empty.
        w = 8'h81; s_data = w; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("byp_first_lsb", k, obs_l, ev(1, k == 7, w[k], 3'(k), 1, 1));
            if (k == 7) begin
                s_data = 8'hC3; s_valid = 1'b1;
            end
            tick();
        end
        s_valid = 1'b0;
        w = 8'hC3;
        check("byp_start_msb", 0, obs_m, ev(1, 0, w[7], 3'd7, 1, 1));
        for (int k = 0; k < 8; k++) begin
            check("byp_second_lsb", k, obs_l, ev(1, k == 7, w[k], 3'(k), 1, 1));
            tick();
        end
        check("byp_idle_lsb", 0, obs_l, ev(0, 0, 0, 3'd0, 0, 1));

        // Reset in the middle of a word drops the rest of it.
        w = 8'hA5; s_data = w; s_valid = 1'b1; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rstmid_lsb", k, obs_l, ev(1, 0, w[k], 3'(k), 1, 1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rstmid_after_lsb", k, obs_l, ev(0, 0, 0, 3'd0, 0, 1));
            check("rstmid_after_msb", k, obs_m, ev(0, 0, 0, 3'd0, 0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
